rf_wb_arbiter: RTL and testbench
================================

# rf_wb_arbiter

Shares the single register-file write port (RFWr/A3/WD) among three write-back requesters: ALU result, memory load, and debug/host write. Each requester gets a valid/ready handshake under round-robin arbitration. The selected write is registered into a one-cycle commit stage that drives the register file. A pending-write scoreboard over x1–x31 lets the decode stage detect read-after-write hazards on rs1/rs2.

## Interface
Parameters:
- DW, 32, data width of register-file write data
- AW, 5, register address width (2^AW registers; x0 hardwired zero)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, asynchronous, active-high
- req_valid  in  3  per-requester write request; bit0 ALU, bit1 MEM, bit2 DBG
- req_ready  out  3  one-hot grant, combinational from req_valid and rr_ptr
- req_addr0/1/2  in  AW each  destination register per requester
- req_data0/1/2  in  DW each  write data per requester
- issue_valid  in  1  decode issued an instruction that will write issue_addr
- issue_addr  in  AW  destination register being reserved
- rs1, rs2  in  AW each  source registers being queried by decode
- busy1, busy2  out  1 each  combinational: scoreboard bit of rs1/rs2; always 0 for x0
- rf_we  out  1  registered write enable to register file
- rf_wa  out  AW  registered write address
- rf_wd  out  DW  registered write data

## Operation
- Handshake: requester i is accepted in the cycle where req_valid[i] && req_ready[i]. At most one bit of req_ready is high. req_ready[i] is never high without req_valid[i]. The requester holds addr/data stable while valid and not ready.
- Arbitration: rr_ptr (2 bits, values 0..2). The grant goes to the first valid requester scanning rr_ptr, rr_ptr+1, rr_ptr+2 (mod 3). On a grant to i, rr_ptr <= (i+1) mod 3. With no grant, rr_ptr holds.
- Commit stage: on a grant, rf_we <= (granted addr != 0), rf_wa <= addr, rf_wd <= data. With no grant, rf_we <= 0 and rf_wa/rf_wd hold.
- Writes to x0 are accepted (ready asserted, pointer advances) but never produce rf_we and never touch the scoreboard.
- Scoreboard: busy[1..2^AW-1], busy[0] constant 0.
  - Set: issue_valid with issue_addr != 0 sets busy[issue_addr] at the clock edge.
  - Clear: in a cycle with rf_we=1, busy[rf_wa] clears at the edge ending that cycle, i.e. the same edge where the register file captures the data.
  - Set and clear of the same register at the same edge: set wins, because a newer producer is reserved.
  - Setting an already-busy register leaves it busy; no counting.
- busy1/busy2 reflect the current register state and give no bypass of a same-cycle set or clear.

## Timing
- Reset values: rf_we=0, rf_wa=0, rf_wd=0, rr_ptr=0, all busy bits 0, so busy1=busy2=0. req_ready is 0 while req_valid=0.
- Latency: grant in cycle N → rf_we=1 in cycle N+1 → register file written at the end of N+1 → busy bit low from cycle N+2.
- Throughput: one write per cycle, sustained, with no bubbles between back-to-back grants.
- Reset asserted mid-operation: the commit stage is dropped immediately (rf_we=0 asynchronously) and the in-flight write is lost. The scoreboard clears and rr_ptr returns to 0.
- All three requesters valid continuously: grants are served in order 0,1,2,0,1,2,… from reset, and no requester waits more than 2 cycles.

## Test plan
- Reset: assert rst mid-stream with rf_we=1 → rf_we=0 the same cycle, busy1=busy2=0 for any rs1/rs2, rr_ptr=0 so the next all-valid grant goes to ALU.
- Single write: ALU valid, addr=5, data=0xDEADBEEF at cycle N → req_ready=3'b001 in N; rf_we=1, rf_wa=5, rf_wd=0xDEADBEEF in N+1; rf_we=0 in N+2.
- Round-robin: all three valid for 6 cycles with addrs 1/2/3 → grant order ALU,MEM,DBG,ALU,MEM,DBG; rf_wa sequence 1,2,3,1,2,3 one cycle delayed. Then MEM drops → alternation ALU/DBG.
- Scoreboard: issue addr=7 at cycle 0 → busy1=1 for rs1=7 from cycle 1. MEM write addr=7 granted at cycle 3 → busy still 1 in cycle 4 (rf_we=1), busy=0 in cycle 5.
- Set-clear collision: rf_we=1, rf_wa=9 in the same cycle as issue_valid with issue_addr=9 → busy[9] stays 1 afterwards.
- x0 handling: DBG write addr=0, data=0x1234 → req_ready[2]=1 and rr_ptr advances, rf_we stays 0. issue_addr=0 → busy1=0 for rs1=0.

Source files
------------

// File: rtl/rf_wb_arbiter.sv
// Register-file write-back arbiter.
// Three requesters (ALU, MEM, DBG) share one register-file write port through a
// round-robin valid/ready handshake. The winning write is registered into a
// one-cycle commit stage. A pending-write scoreboard flags destination registers
// that decode has reserved but that have not yet been written back.
module rf_wb_arbiter #(
    parameter int unsigned DW = 32,
    parameter int unsigned AW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [2:0]    req_valid,
    output logic [2:0]    req_ready,
    input  logic [AW-1:0] req_addr0,
    input  logic [AW-1:0] req_addr1,
    input  logic [AW-1:0] req_addr2,
    input  logic [DW-1:0] req_data0,
    input  logic [DW-1:0] req_data1,
    input  logic [DW-1:0] req_data2,
    input  logic          issue_valid,
    input  logic [AW-1:0] issue_addr,
    input  logic [AW-1:0] rs1,
    input  logic [AW-1:0] rs2,
    output logic          busy1,
    output logic          busy2,
    output logic          rf_we,
    output logic [AW-1:0] rf_wa,
    output logic [DW-1:0] rf_wd
);

    localparam int unsigned NREG = 1 << AW;

    logic [1:0]      rr_ptr_q;
    logic [1:0]      rr_ptr_d;
    logic            grant;
    logic [AW-1:0]   sel_addr;
    logic [DW-1:0]   sel_data;
    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;

    // Round-robin grant: first valid requester scanning from rr_ptr upward (mod 3).
    always_comb begin
        req_ready = 3'b000;
        case (rr_ptr_q)
            2'd1: begin
                if      (req_valid[1]) req_ready = 3'b010;
                else if (req_valid[2]) req_ready = 3'b100;
                else if (req_valid[0]) req_ready = 3'b001;
            end
            2'd2: begin
                if      (req_valid[2]) req_ready = 3'b100;
                else if (req_valid[0]) req_ready = 3'b001;
                else if (req_valid[1]) req_ready = 3'b010;
            end
            // Encoding 3 is unreachable; treat it like 0.
            default: begin
                if      (req_valid[0]) req_ready = 3'b001;
                else if (req_valid[1]) req_ready = 3'b010;
                else if (req_valid[2]) req_ready = 3'b100;
            end
        endcase
    end

    assign grant = |req_ready;

    // Select the granted requester's address/data and the following pointer value.
    always_comb begin
        sel_addr = req_addr0;
        sel_data = req_data0;
        rr_ptr_d = rr_ptr_q;
        if (req_ready[0]) begin
            rr_ptr_d = 2'd1;
        end else if (req_ready[1]) begin
            sel_addr = req_addr1;
            sel_data = req_data1;
            rr_ptr_d = 2'd2;
        end else if (req_ready[2]) begin
            sel_addr = req_addr2;
            sel_data = req_data2;
            rr_ptr_d = 2'd0;
        end
    end

    // Round-robin pointer; holds when nothing is granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rr_ptr_q <= 2'd0;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Commit stage: x0 writes are accepted but never raise rf_we.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rf_we <= 1'b0;
            rf_wa <= '0;
            rf_wd <= '0;
        end else if (grant) begin
            rf_we <= (sel_addr != '0);
            rf_wa <= sel_addr;
            rf_wd <= sel_data;
        end else begin
            rf_we <= 1'b0;
        end
    end

    // Scoreboard next state: clear on commit, then set on issue so a newer reservation wins.
    always_comb begin
        busy_d = busy_q;
        if (rf_we) begin
            busy_d[rf_wa] = 1'b0;
        end
        if (issue_valid && (issue_addr != '0)) begin
            busy_d[issue_addr] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    // Scoreboard state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    // No bypass: lookups reflect the registered scoreboard only.
    assign busy1 = busy_q[rs1];
    assign busy2 = busy_q[rs2];

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Self-checking bench for rf_wb_arbiter: a vector table from reset, directed
// multi-cycle sequences, then random traffic against a behavioural model.
module tb_rf_wb_arbiter;

    localparam int AW = 5;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [2:0]    req_valid;
    logic [2:0]    req_ready;
    logic [AW-1:0] req_addr0, req_addr1, req_addr2;
    logic [DW-1:0] req_data0, req_data1, req_data2;
    logic          issue_valid;
    logic [AW-1:0] issue_addr;
    logic [AW-1:0] rs1, rs2;
    logic          busy1, busy2;
    logic          rf_we;
    logic [AW-1:0] rf_wa;
    logic [DW-1:0] rf_wd;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rf_wb_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_addr0  (req_addr0),
        .req_addr1  (req_addr1),
        .req_addr2  (req_addr2),
        .req_data0  (req_data0),
        .req_data1  (req_data1),
        .req_data2  (req_data2),
        .issue_valid(issue_valid),
        .issue_addr (issue_addr),
        .rs1        (rs1),
        .rs2        (rs2),
        .busy1      (busy1),
        .busy2      (busy2),
        .rf_we      (rf_we),
        .rf_wa      (rf_wa),
        .rf_wd      (rf_wd)
    );

    typedef struct {
        logic [2:0]    valid;
        logic [AW-1:0] a0;
        logic [AW-1:0] a1;
        logic [AW-1:0] a2;
        logic [2:0]    exp_ready;
        logic          exp_we;
        logic [AW-1:0] exp_wa;
    } vec_t;

    vec_t tbl[14];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        req_valid   = 3'b000;
        req_addr0   = '0;
        req_addr1   = '0;
        req_addr2   = '0;
        req_data0   = '0;
        req_data1   = '0;
        req_data2   = '0;
        issue_valid = 1'b0;
        issue_addr  = '0;
        rs1         = '0;
        rs2         = '0;
    endtask

    // Leaves the bench just after a falling edge with reset released.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Behavioural reference model state.
    int            m_ptr;
    bit            m_busy[32];
    logic          m_we;
    logic [AW-1:0] m_wa;
    logic [DW-1:0] m_wd;
    logic          rv[3];
    logic [AW-1:0] ra[3];
    logic [DW-1:0] rd[3];

    initial begin
        rst = 1'b1;
        idle_inputs();

        // Rows are consecutive cycles from reset; data is unused by the table.
        tbl[0]  = '{3'b111, 5'd1, 5'd2, 5'd3, 3'b001, 1'b0, 5'd0};
        tbl[1]  = '{3'b111, 5'd1, 5'd2, 5'd3, 3'b010, 1'b1, 5'd1};
        tbl[2]  = '{3'b111, 5'd1, 5'd2, 5'd3, 3'b100, 1'b1, 5'd2};
        tbl[3]  = '{3'b111, 5'd1, 5'd2, 5'd3, 3'b001, 1'b1, 5'd3};
        tbl[4]  = '{3'b111, 5'd1, 5'd2, 5'd3, 3'b010, 1'b1, 5'd1};
        tbl[5]  = '{3'b111, 5'd1, 5'd2, 5'd3, 3'b100, 1'b1, 5'd2};
        tbl[6]  = '{3'b101, 5'd1, 5'd2, 5'd3, 3'b001, 1'b1, 5'd3};
        tbl[7]  = '{3'b101, 5'd1, 5'd2, 5'd3, 3'b100, 1'b1, 5'd1};
        tbl[8]  = '{3'b101, 5'd1, 5'd2, 5'd3, 3'b001, 1'b1, 5'd3};
        tbl[9]  = '{3'b000, 5'd1, 5'd2, 5'd3, 3'b000, 1'b1, 5'd1};
        tbl[10] = '{3'b010, 5'd1, 5'd0, 5'd3, 3'b010, 1'b0, 5'd1};
        tbl[11] = '{3'b000, 5'd1, 5'd2, 5'd3, 3'b000, 1'b0, 5'd0};
        tbl[12] = '{3'b011, 5'd1, 5'd2, 5'd3, 3'b001, 1'b0, 5'd0};
        tbl[13] = '{3'b000, 5'd1, 5'd2, 5'd3, 3'b000, 1'b1, 5'd1};

        // Reset state.
        do_reset();
        rs1 = 5'd7;
        rs2 = 5'd31;
        #1;
        chk("reset_rf_we", rf_we, 1'b0);
        chk("reset_rf_wa", rf_wa, 5'd0);
        chk("reset_rf_wd", rf_wd, 32'd0);
        chk("reset_ready", req_ready, 3'b000);
        chk("reset_busy1", busy1, 1'b0);
        chk("reset_busy2", busy2, 1'b0);
        @(negedge clk);

        // Table: round-robin order, MEM dropping out, idle hold, x0 write.
        do_reset();
        for (int i = 0; i < 14; i++) begin
            req_valid = tbl[i].valid;
            req_addr0 = tbl[i].a0;
            req_addr1 = tbl[i].a1;
            req_addr2 = tbl[i].a2;
            #1;
            chk($sformatf("tbl%0d_ready", i), req_ready, tbl[i].exp_ready);
            chk($sformatf("tbl%0d_we", i), rf_we, tbl[i].exp_we);
            if (tbl[i].exp_we) chk($sformatf("tbl%0d_wa", i), rf_wa, tbl[i].exp_wa);
            @(negedge clk);
        end

        // Single write latency.
        do_reset();
        req_valid = 3'b001;
        req_addr0 = 5'd5;
        req_data0 = 32'hDEADBEEF;
        #1;
        chk("single_ready", req_ready, 3'b001);
        @(negedge clk);
        req_valid = 3'b000;
        #1;
        chk("single_we", rf_we, 1'b1);
        chk("single_wa", rf_wa, 5'd5);
        chk("single_wd", rf_wd, 32'hDEADBEEF);
        @(negedge clk);
        #1;
        chk("single_we_drop", rf_we, 1'b0);
        @(negedge clk);

        // Scoreboard set/clear timing.
        do_reset();
        issue_valid = 1'b1;
        issue_addr  = 5'd7;
        rs1         = 5'd7;
        #1;
        chk("sb_c0_nobypass", busy1, 1'b0);
        @(negedge clk);
        issue_valid = 1'b0;
        #1;
        chk("sb_c1_busy", busy1, 1'b1);
        @(negedge clk);
        @(negedge clk);
        req_valid = 3'b010;
        req_addr1 = 5'd7;
        req_data1 = 32'h0000_0777;
        #1;
        chk("sb_c3_ready", req_ready, 3'b010);
        chk("sb_c3_busy", busy1, 1'b1);
        @(negedge clk);
        req_valid = 3'b000;
        #1;
        chk("sb_c4_we", rf_we, 1'b1);
        chk("sb_c4_busy", busy1, 1'b1);
        @(negedge clk);
        #1;
        chk("sb_c5_clear", busy1, 1'b0);
        @(negedge clk);

        // Set and clear of the same register at one edge: set wins.
        issue_valid = 1'b1;
        issue_addr  = 5'd9;
        @(negedge clk);
        issue_valid = 1'b0;
        req_valid   = 3'b001;
        req_addr0   = 5'd9;
        req_data0   = 32'h0000_0999;
        #1;
        chk("col_ready", req_ready, 3'b001);
        @(negedge clk);
        req_valid   = 3'b000;
        issue_valid = 1'b1;
        issue_addr  = 5'd9;
        rs2         = 5'd9;
        #1;
        chk("col_we", rf_we, 1'b1);
        chk("col_wa", rf_wa, 5'd9);
        chk("col_busy_before", busy2, 1'b1);
        @(negedge clk);
        issue_valid = 1'b0;
        #1;
        chk("col_busy_after", busy2, 1'b1);
        @(negedge clk);
        #1;
        chk("col_busy_held", busy2, 1'b1);
        @(negedge clk);

        // x0 writes: accepted, pointer advances, no rf_we, no scoreboard effect.
        do_reset();
        req_valid = 3'b001;
        req_addr0 = 5'd3;
        #1;
        chk("x0_pre_ready", req_ready, 3'b001);
        @(negedge clk);
        req_valid = 3'b100;
        req_addr2 = 5'd0;
        req_data2 = 32'h0000_1234;
        #1;
        chk("x0_ready", req_ready, 3'b100);
        @(negedge clk);
        req_valid   = 3'b111;
        req_addr0   = 5'd1;
        req_addr1   = 5'd2;
        req_addr2   = 5'd3;
        issue_valid = 1'b1;
        issue_addr  = 5'd0;
        #1;
        chk("x0_no_we", rf_we, 1'b0);
        chk("x0_ptr_adv", req_ready, 3'b001);
        @(negedge clk);
        req_valid   = 3'b000;
        issue_valid = 1'b0;
        rs1         = 5'd0;
        #1;
        chk("x0_busy", busy1, 1'b0);
        @(negedge clk);

        // Reset mid-stream drops the in-flight commit and scoreboard at once.
        do_reset();
        issue_valid = 1'b1;
        issue_addr  = 5'd4;
        @(negedge clk);
        issue_valid = 1'b0;
        req_valid   = 3'b001;
        req_addr0   = 5'd4;
        req_data0   = 32'h4444_4444;
        rs1         = 5'd4;
        @(negedge clk);
        req_valid = 3'b000;
        #1;
        chk("mid_we_before", rf_we, 1'b1);
        chk("mid_busy_before", busy1, 1'b1);
        rst = 1'b1;
        #1;
        chk("mid_we_async", rf_we, 1'b0);
        chk("mid_busy1", busy1, 1'b0);
        chk("mid_busy2", busy2, 1'b0);
        @(negedge clk);
        rst       = 1'b0;
        req_valid = 3'b111;
        #1;
        chk("mid_ptr_reset", req_ready, 3'b001);
        @(negedge clk);

        // Random traffic against the model.
        do_reset();
        m_ptr = 0;
        foreach (m_busy[i]) m_busy[i] = 1'b0;
        m_we = 1'b0;
        m_wa = '0;
        m_wd = '0;
        for (int i = 0; i < 3; i++) begin
            rv[i] = 1'b0;
            ra[i] = '0;
            rd[i] = '0;
        end
        for (int cyc = 0; cyc < 600; cyc++) begin
            int g;
            logic [2:0] exp_ready;
            // A requester keeps its request until accepted; otherwise it picks a fresh one.
            for (int i = 0; i < 3; i++) begin
                if (!rv[i]) begin
                    rv[i] = ($urandom_range(0, 99) < 55);
                    ra[i] = AW'($urandom_range(0, 15));
                    rd[i] = $urandom;
                end
            end
            req_valid   = {rv[2], rv[1], rv[0]};
            req_addr0   = ra[0];
            req_addr1   = ra[1];
            req_addr2   = ra[2];
            req_data0   = rd[0];
            req_data1   = rd[1];
            req_data2   = rd[2];
            issue_valid = ($urandom_range(0, 99) < 35);
            issue_addr  = AW'($urandom_range(0, 15));
            rs1         = AW'($urandom_range(0, 15));
            rs2         = AW'($urandom_range(0, 15));
            #1;
            g = -1;
            for (int k = 0; k < 3; k++) begin
                if (g < 0 && rv[(m_ptr + k) % 3]) g = (m_ptr + k) % 3;
            end
            exp_ready = (g >= 0) ? 3'(1 << g) : 3'b000;
            chk("rnd_ready", req_ready, exp_ready);
            chk("rnd_busy1", busy1, m_busy[rs1]);
            chk("rnd_busy2", busy2, m_busy[rs2]);
            chk("rnd_we", rf_we, m_we);
            if (m_we) begin
                chk("rnd_wa", rf_wa, m_wa);
                chk("rnd_wd", rf_wd, m_wd);
            end
            // Model update for the coming edge.
            if (m_we) m_busy[m_wa] = 1'b0;
            if (issue_valid && issue_addr != 0) m_busy[issue_addr] = 1'b1;
            if (g >= 0) begin
                m_we  = (ra[g] != 0);
                m_wa  = ra[g];
                m_wd  = rd[g];
                m_ptr = (g + 1) % 3;
                rv[g] = 1'b0;
            end else begin
                m_we = 1'b0;
            end
            @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
